// File: rtl/otter_mem_pkg.sv
// Shared types and sizing for the OTTER main-memory arbiter.
package otter_mem_pkg;

    localparam int unsigned LINE_WORDS_DEF = 8;
    localparam int unsigned BEAT_W         = $clog2(LINE_WORDS_DEF);
    localparam int unsigned OFFS_W         = BEAT_W + 2;

    typedef enum logic [1:0] {
        IDLE,
        XFER,
        DONE
    } state_t;

    typedef enum logic {
        IC = 1'b0,
        DC = 1'b1
    } req_id_t;

endpackage

// File: rtl/otter_rr_arb2.sv
// Two-way round-robin picker: a lone request wins, a tie goes to whoever was not served last.
module otter_rr_arb2
    import otter_mem_pkg::*;
(
    input  logic [1:0] req,
    input  req_id_t    last_grant,
    output logic       gnt_valid,
    output req_id_t    gnt_id
);

    always_comb begin
        gnt_valid = |req;
        gnt_id    = IC;
        if (req == 2'b11) begin
            gnt_id = (last_grant == IC) ? DC : IC;
        end else if (req[1]) begin
            gnt_id = DC;
        end
    end

endmodule

// File: rtl/otter_mem_arbiter.sv
// Shares the single main-memory port between I-cache fills and D-cache fills/writebacks,
// one whole-line burst per grant.
module otter_mem_arbiter
    import otter_mem_pkg::*;
#(
    parameter int unsigned LINE_WORDS = LINE_WORDS_DEF,
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32
) (
    input  logic                          CLK,
    input  logic                          RST_N,
    input  logic                          ic_req,
    input  logic [ADDR_W-1:0]             ic_addr,
    output logic [DATA_W-1:0]             ic_rdata,
    output logic                          ic_rvalid,
    output logic                          ic_done,
    input  logic                          dc_req,
    input  logic                          dc_we,
    input  logic [ADDR_W-1:0]             dc_addr,
    input  logic [DATA_W-1:0]             dc_wdata,
    output logic [$clog2(LINE_WORDS)-1:0] dc_beat,
    output logic [DATA_W-1:0]             dc_rdata,
    output logic                          dc_rvalid,
    output logic                          dc_done,
    output logic                          mem_req,
    output logic                          mem_we,
    output logic [ADDR_W-1:0]             mem_addr,
    output logic [DATA_W-1:0]             mem_wdata,
    input  logic                          mem_ack,
    input  logic [DATA_W-1:0]             mem_rdata
);

    localparam int unsigned BW = $clog2(LINE_WORDS);

    state_t            state;
    req_id_t           gnt;
    req_id_t           last_grant;
    logic              we_lat;
    logic [ADDR_W-1:0] base;
    logic [BW-1:0]     beat;
    logic [BW-1:0]     beat_nxt;

    logic              arb_valid;
    req_id_t           arb_id;
    logic [ADDR_W-1:0] sel_addr;
    logic [ADDR_W-1:0] sel_base;

    otter_rr_arb2 u_arb (
        .req        ({dc_req, ic_req}),
        .last_grant (last_grant),
        .gnt_valid  (arb_valid),
        .gnt_id     (arb_id)
    );

    always_comb begin
        sel_addr = (arb_id == DC) ? dc_addr : ic_addr;
        sel_base = sel_addr & ~ADDR_W'(LINE_WORDS * 4 - 1);
        beat_nxt = beat + BW'(1);
    end

    // Write data is a straight pass-through of the D-cache word mux, which follows dc_beat.
    always_comb begin
        mem_wdata = (state == XFER) ? dc_wdata : '0;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state      <= IDLE;
            gnt        <= IC;
            last_grant <= DC;
            we_lat     <= 1'b0;
            base       <= '0;
            beat       <= '0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            dc_beat    <= '0;
            ic_rdata   <= '0;
            ic_rvalid  <= 1'b0;
            ic_done    <= 1'b0;
            dc_rdata   <= '0;
            dc_rvalid  <= 1'b0;
            dc_done    <= 1'b0;
        end else begin
            ic_rvalid <= 1'b0;
            dc_rvalid <= 1'b0;
            ic_done   <= 1'b0;
            dc_done   <= 1'b0;
            case (state)
                IDLE: begin
                    if (arb_valid) begin
                        state    <= XFER;
                        gnt      <= arb_id;
                        we_lat   <= (arb_id == DC) && dc_we;
                        base     <= sel_base;
                        beat     <= '0;
                        mem_req  <= 1'b1;
                        mem_we   <= (arb_id == DC) && dc_we;
                        mem_addr <= sel_base;
                        dc_beat  <= '0;
                    end
                end
                XFER: begin
                    if (mem_ack) begin
                        if (!we_lat) begin
                            if (gnt == DC) begin
                                dc_rdata  <= mem_rdata;
                                dc_rvalid <= 1'b1;
                            end else begin
                                ic_rdata  <= mem_rdata;
                                ic_rvalid <= 1'b1;
                            end
                        end
                        if (&beat) begin
                            // Done is raised on the same edge as the final rvalid.
                            state    <= DONE;
                            beat     <= '0;
                            mem_req  <= 1'b0;
                            mem_we   <= 1'b0;
                            mem_addr <= '0;
                            dc_beat  <= '0;
                            if (gnt == DC) begin
                                dc_done <= 1'b1;
                            end else begin
                                ic_done <= 1'b1;
                            end
                        end else begin
                            beat     <= beat_nxt;
                            mem_addr <= base + ADDR_W'({beat_nxt, 2'b00});
                            if (gnt == DC) begin
                                dc_beat <= beat_nxt;
                            end
                        end
                    end
                end
                DONE: begin
                    last_grant <= gnt;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_otter_mem_arbiter.sv
// Directed plus randomized bench for otter_mem_arbiter against a transaction-level model.
module tb_otter_mem_arbiter;

    localparam int LW = 8;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        ic_req, dc_req, dc_we, mem_ack;
    logic [31:0] ic_addr, dc_addr, dc_wdata, mem_rdata, wpat;
    logic [31:0] ic_rdata, dc_rdata, mem_addr, mem_wdata;
    logic        ic_rvalid, ic_done, dc_rvalid, dc_done, mem_req, mem_we;
    logic [2:0]  dc_beat;

    int checks   = 0;
    int failures = 0;
    bit last_dc;

    always #5 CLK = ~CLK;

    // D-cache word mux: the word written on beat k is wpat + k.
    assign dc_wdata = wpat + 32'(dc_beat);

    otter_mem_arbiter #(.LINE_WORDS(LW), .ADDR_W(32), .DATA_W(32)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .ic_req(ic_req), .ic_addr(ic_addr), .ic_rdata(ic_rdata),
        .ic_rvalid(ic_rvalid), .ic_done(ic_done),
        .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
        .dc_beat(dc_beat), .dc_rdata(dc_rdata), .dc_rvalid(dc_rvalid), .dc_done(dc_done),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_req"},   {31'd0, mem_req}, 0);
        chk({tag, "_we"},    {31'd0, mem_we}, 0);
        chk({tag, "_addr"},  mem_addr, 0);
        chk({tag, "_wdata"}, mem_wdata, 0);
        chk({tag, "_beat"},  {29'd0, dc_beat}, 0);
        chk({tag, "_icrd"},  ic_rdata, 0);
        chk({tag, "_dcrd"},  dc_rdata, 0);
        chk({tag, "_flags"}, {28'd0, ic_rvalid, ic_done, dc_rvalid, dc_done}, 0);
    endtask

    task automatic do_reset();
        ic_req = 0; dc_req = 0; mem_ack = 0;
        RST_N = 0;
        repeat (2) @(negedge CLK);
        chk_all_zero("reset");
        RST_N = 1;
        last_dc = 1;
    endtask

    // One burst for the requester the model expects to win; starts at an IDLE negedge.
    task automatic serve(input bit dc, input int stall_beat, input int stall_n,
                         input bit rnd, input bit rearm_ic, input bit rearm_dc);
        logic [31:0] base, exp_rd;
        bit          we, ack, exp_rv;
        int          i, w;
        we   = dc ? dc_we : 1'b0;
        base = (dc ? dc_addr : ic_addr) & ~32'(LW * 4 - 1);
        @(negedge CLK);
        chk("grant_req",  {31'd0, mem_req}, 1);
        chk("grant_addr", mem_addr, base);
        if (rearm_ic) begin ic_addr = $urandom; ic_req = 1; end
        if (rearm_dc) begin dc_addr = $urandom; dc_req = 1; end
        exp_rv = 0; exp_rd = 0; i = 0; w = 0;
        while (i < LW) begin
            chk("xfer_req",  {31'd0, mem_req}, 1);
            chk("xfer_addr", mem_addr, base + 32'(4 * i));
            chk("xfer_we",   {31'd0, mem_we}, {31'd0, we});
            chk("dc_beat",   {29'd0, dc_beat}, dc ? 32'(i) : 0);
            if (we) chk("wdata", mem_wdata, wpat + 32'(i));
            chk("ic_rvalid", {31'd0, ic_rvalid}, {31'd0, exp_rv && !dc});
            chk("dc_rvalid", {31'd0, dc_rvalid}, {31'd0, exp_rv && dc});
            if (exp_rv) chk("rdata", dc ? dc_rdata : ic_rdata, exp_rd);
            chk("done_early", {30'd0, ic_done, dc_done}, 0);
            if (i == stall_beat)  ack = (w == stall_n);
            else if (rnd)         ack = (w >= 3) || ($urandom_range(0, 2) != 0);
            else                  ack = 1;
            mem_ack   = ack;
            mem_rdata = $urandom;
            if (ack) exp_rd = mem_rdata;
            exp_rv = ack && !we;
            @(negedge CLK);
            if (ack) begin i++; w = 0; end else w++;
        end
        mem_ack   = 1'($urandom_range(0, 1));
        mem_rdata = $urandom;
        chk("done_req",  {31'd0, mem_req}, 0);
        chk("done_we",   {31'd0, mem_we}, 0);
        chk("ic_done",   {31'd0, ic_done}, {31'd0, !dc});
        chk("dc_done",   {31'd0, dc_done}, {31'd0, dc});
        chk("last_ic_rv", {31'd0, ic_rvalid}, {31'd0, !we && !dc});
        chk("last_dc_rv", {31'd0, dc_rvalid}, {31'd0, !we && dc});
        if (!we) chk("last_rdata", dc ? dc_rdata : ic_rdata, exp_rd);
        if (dc) dc_req = 0; else ic_req = 0;
        last_dc = dc;
        @(negedge CLK);
        chk("idle_req",   {31'd0, mem_req}, 0);
        chk("idle_flags", {28'd0, ic_rvalid, ic_done, dc_rvalid, dc_done}, 0);
        mem_ack = 0;
    endtask

    // Both requesters held: grants must alternate, starting with the one not served last.
    task automatic tie_chain(input int n, input bit we);
        bit cur;
        @(negedge CLK);
        ic_addr = $urandom; dc_addr = $urandom; dc_we = we; wpat = $urandom;
        ic_req = 1; dc_req = 1;
        cur = !last_dc;
        for (int k = 0; k < n; k++) begin
            serve(cur, -1, 0, 1, (k >= 1 && k < n - 1) && cur, (k >= 1 && k < n - 1) && !cur);
            cur = !cur;
        end
    endtask

    initial begin
        ic_req = 0; dc_req = 0; dc_we = 0; mem_ack = 0;
        ic_addr = 0; dc_addr = 0; mem_rdata = 0; wpat = 0;
        do_reset();

        // IC fill, no wait states
        @(negedge CLK);
        ic_addr = 32'h0000_1034; ic_req = 1;
        serve(0, -1, 0, 0, 0, 0);

        // DC writeback, word k = 0xA0 + k
        @(negedge CLK);
        wpat = 32'hA0; dc_we = 1; dc_addr = 32'h2000; dc_req = 1;
        serve(1, -1, 0, 0, 0, 0);

        // DC fill stalled three cycles on beat 2
        @(negedge CLK);
        dc_we = 0; dc_addr = 32'h0000_3F44; dc_req = 1;
        serve(1, 2, 3, 0, 0, 0);

        // Reset during beat 4 of an IC fill
        @(negedge CLK);
        ic_addr = 32'h0000_5018; ic_req = 1;
        @(negedge CLK);
        for (int b = 0; b < 4; b++) begin
            mem_ack = 1; mem_rdata = $urandom;
            @(negedge CLK);
        end
        chk("rst_pre_addr", mem_addr, 32'h0000_5010);
        chk("rst_pre_rv",   {31'd0, ic_rvalid}, 1);
        mem_ack = 0;
        #2 RST_N = 0;
        #1 chk_all_zero("async_rst");
        ic_req = 0;
        @(negedge CLK);
        chk("rst_no_done", {31'd0, ic_done}, 0);
        RST_N = 1;
        last_dc = 1;
        @(negedge CLK);
        chk("post_rst_done", {31'd0, ic_done}, 0);
        ic_addr = 32'h0000_6004; ic_req = 1;
        serve(0, -1, 0, 1, 0, 0);

        // mem_ack in IDLE is ignored
        @(negedge CLK);
        for (int c = 0; c < 3; c++) begin
            mem_ack = 1; mem_rdata = $urandom;
            @(negedge CLK);
            chk("idle_ack_req",   {31'd0, mem_req}, 0);
            chk("idle_ack_flags", {28'd0, ic_rvalid, ic_done, dc_rvalid, dc_done}, 0);
        end
        mem_ack = 0;

        // Simultaneous requests straight after reset, then sustained alternation
        do_reset();
        tie_chain(4, 0);
        tie_chain(3, 1);

        // Randomized mix of single and contended requests with random wait states
        for (int t = 0; t < 12; t++) begin
            case ($urandom_range(0, 2))
                0: begin
                    @(negedge CLK);
                    ic_addr = $urandom; ic_req = 1;
                    serve(0, -1, 0, 1, 0, 0);
                end
                1: begin
                    @(negedge CLK);
                    dc_addr = $urandom; dc_we = 1'($urandom_range(0, 1));
                    wpat = $urandom; dc_req = 1;
                    serve(1, -1, 0, 1, 0, 0);
                end
                default: tie_chain(2 + $urandom_range(0, 2), 1'($urandom_range(0, 1)));
            endcase
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/otter_mem_arbiter.md
Name: otter_mem_arbiter

Overview:
- Shares the OTTER's single main-memory port between the I-cache (read-only line fills) and the D-cache (line fills and dirty-line writebacks).
- Each granted requester gets a whole-line burst of LINE_WORDS word transfers, paced by a word-level req/ack handshake to memory.
- Sits between the two cache controllers and the memory module inside the OTTER MCU, below OTTER_Wrapper_Programmable.

Parameters:
LINE_WORDS, 8, words per cache line; power of two, at least 2
ADDR_W, 32, byte address width
DATA_W, 32, word width

Ports:
CLK  in  1  system clock, rising edge
RST_N  in  1  asynchronous active-low reset
ic_req  in  1  I-cache line-fill request; held until ic_done
ic_addr  in  ADDR_W  I-cache line address; low bits ignored
ic_rdata  out  DATA_W  fill word
ic_rvalid  out  1  ic_rdata valid, one pulse per beat
ic_done  out  1  one-cycle pulse, I-cache burst complete
dc_req  in  1  D-cache request; held until dc_done
dc_we  in  1  1 = writeback, 0 = fill; stable while dc_req is high
dc_addr  in  ADDR_W  D-cache line address
dc_wdata  in  DATA_W  writeback word selected by dc_beat
dc_beat  out  $clog2(LINE_WORDS)  current beat index, for the D-cache word mux
dc_rdata  out  DATA_W  fill word
dc_rvalid  out  1  dc_rdata valid, one pulse per beat
dc_done  out  1  one-cycle pulse, D-cache burst complete
mem_req  out  1  memory word request
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  word byte-address
mem_wdata  out  DATA_W  write word
mem_ack  in  1  memory completes the current word; rdata is valid in the same cycle
mem_rdata  in  DATA_W  read word

Behaviour:
- States: IDLE, XFER, DONE.
- Reset (async, RST_N low): state=IDLE, beat=0, last_grant=DC, every output 0. This applies mid-burst as well: the burst is abandoned, no done pulse is issued, and mem_req drops immediately.
- IDLE transition:
  - If any request is pending at a rising edge, go to XFER.
  - Latch gnt, base = addr with the low $clog2(LINE_WORDS)+2 bits cleared, and we (dc_we for DC, 0 for IC).
  - Set beat=0.
- Arbitration (IDLE only):
  - With a single request, that requester wins.
  - With both requesting, the requester that is not last_grant wins. After reset the I-cache wins the first tie.
- XFER outputs:
  - mem_req=1, mem_we=we_lat.
  - mem_addr = base + 4*beat.
  - mem_wdata = dc_wdata.
  - dc_beat = beat while gnt=DC, else 0.
- XFER with mem_ack=0: hold all outputs; no limit on wait states.
- XFER with mem_ack=1:
  - beat increments.
  - On a read, mem_rdata is registered into the granted requester's rdata and its rvalid pulses in the next cycle.
  - On the ack of beat LINE_WORDS-1, go to DONE and reset beat to 0. There is no wrap: the burst ends exactly at the last beat.
- DONE:
  - mem_req=0.
  - The granted requester's done pulses for one cycle. On a read burst this coincides with the final rvalid.
  - last_grant=gnt, then go to IDLE.
- Requester rule: req must be low in the cycle after done. Because of the pass through IDLE, the same requester cannot be re-granted before it has seen done.
- The non-granted requester's rvalid and done stay 0 at all times.
- mem_ack while not in XFER is ignored.
- Requests arriving during XFER or DONE wait; they are never dropped.
- Throughput: at minimum 1 arbitration cycle + LINE_WORDS beats + 1 done cycle per line.

Decomposition:
- Package otter_mem_pkg holds:
  - enum state_t {IDLE, XFER, DONE}
  - enum req_id_t {IC, DC}
  - localparams BEAT_W=$clog2(LINE_WORDS) and OFFS_W=BEAT_W+2
- Sub-module otter_rr_arb2: combinational 2-way round-robin picker. Inputs are req[1:0] and last_grant; outputs are gnt_valid and gnt_id. Instantiated once.

Test Plan:
1. Reset, then ic_req with ic_addr=0x0000_1034 and mem_ack always 1 → mem_addr steps 0x1020, 0x1024, …, 0x103C; 8 ic_rvalid pulses carry the mem_rdata values; ic_done rises with the 8th rvalid; mem_we stays 0 throughout.
2. dc_req, dc_we=1, dc_addr=0x2000, dc_wdata=0xA0+dc_beat → 8 memory writes at 0x2000–0x201C with data 0xA0–0xA7; dc_rvalid never asserted; a single dc_done pulse.
3. ic_req and dc_req rise together after reset → IC is served first, then DC immediately after. Repeat with both held → grants alternate DC, IC, DC.
4. dc fill with mem_ack stalled 3 cycles on beat 2 → mem_addr/mem_req held at base+8 for 4 cycles; the burst then completes with 8 rvalids total.
5. RST_N driven low during beat 4 of an IC fill → all outputs 0 asynchronously, with no ic_done; after release, a new ic_req starts again from beat 0.
6. mem_ack pulsed while in IDLE → no state change, no rvalid.
